// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_arbiter
// Purpose  : Round-robin arbiter for NUM_REQ level requesters. It holds a
//            registered one-hot grant and an encoded index until the owner
//            releases the grant or drops its request. Priority then rotates
//            to the requester after the last owner. Re-arbitration happens in
//            the same cycle as the end of a hold, so there is no idle bubble.
//
// Optional : `define ARB_HOLD_TIMEOUT_EN compiles in a hold counter. With it,
//            a grant is forcibly ended after MAX_HOLD cycles and a one-cycle
//            timeout pulse is produced. Without it, timeout is tied to 0 and
//            MAX_HOLD only takes part in the parameter sanity check.
//
// Ports    : clk           in   clock, rising edge
//            rst           in   synchronous reset, active-high
//            enable        in   permits new grants
//            req           in   [NUM_REQ] level request vector
//            owner_release in   single-cycle "owner done" pulse. It is named
//                               this way because `release` is a reserved word.
//            grant         out  [NUM_REQ] registered one-hot grant
//            grant_idx     out  [IDX_W] owner index, NUM_REQ when idle
//            grant_valid   out  registered |grant
//            timeout       out  one-cycle pulse on a forced end of a hold
//
// Revision : 1.0  initial release
// ============================================================================
module rr_grant_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int IDX_W    = $clog2(NUM_REQ) + 1,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    input  logic               owner_release,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               timeout
);

    localparam int                 c_PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [0:0]         c_IDLE     = 1'b0;
    localparam logic [0:0]         c_HOLD     = 1'b1;
    localparam logic [IDX_W-1:0]   c_NO_GRANT = IDX_W'(NUM_REQ);
    localparam logic [c_PTR_W-1:0] c_LAST     = c_PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_ONE      = NUM_REQ'(1);

    // IDX_W must be able to hold the invalid code NUM_REQ.
    if (NUM_REQ < 1 || MAX_HOLD < 2 || IDX_W < $clog2(NUM_REQ + 1)) begin : g_param_check
        $error("rr_grant_arbiter: illegal parameter combination");
    end

    logic [0:0]         r_state;
    logic [c_PTR_W-1:0] r_ptr;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_grant_idx;
    logic               r_grant_valid;
    logic               r_timeout;

    logic [c_PTR_W-1:0] w_owner;
    logic [c_PTR_W-1:0] w_owner_next;
    logic [c_PTR_W-1:0] w_base;
    logic [c_PTR_W-1:0] w_sel;
    logic               w_found;
    logic               w_end_req;
    logic               w_to_fire;
    logic               w_end;
    logic               w_new_grant;

    // While holding, grant_idx always carries a valid owner index.
    assign w_owner      = r_grant_idx[c_PTR_W-1:0];
    assign w_owner_next = (w_owner == c_LAST) ? '0 : w_owner + 1'b1;

    // Voluntary end: explicit release, or the owner withdrew its request.
    assign w_end_req = owner_release || !req[w_owner];
    assign w_end     = (r_state == c_HOLD) && (w_end_req || w_to_fire);

    // In IDLE, scan from the stored pointer. At the end of a hold, scan from
    // the slot after the owner. That slot is the pointer value being written
    // on this same edge.
    assign w_base = (r_state == c_HOLD) ? w_owner_next : r_ptr;

    // Circular first-set search starting at w_base.
    always_comb begin : p_select
        int j;
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(w_base) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                w_sel   = c_PTR_W'(j);
            end
        end
    end

    assign w_new_grant = enable && w_found && ((r_state == c_IDLE) || w_end);

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int                 c_CNT_W   = $clog2(MAX_HOLD);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_HOLD - 1);

    logic [c_CNT_W-1:0] r_hold_cnt;

    // A forced end only counts when nothing else ends the hold that cycle.
    // A coincident release or drop is reported as a normal end.
    assign w_to_fire = (r_state == c_HOLD) && (r_hold_cnt == c_CNT_MAX) && !w_end_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (w_new_grant) begin
            r_hold_cnt <= '0;
        end else if ((r_state == c_HOLD) && (r_hold_cnt != c_CNT_MAX)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end
`else
    assign w_to_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_grant_idx   <= c_NO_GRANT;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (w_end) begin
                r_ptr     <= w_owner_next;
                r_timeout <= w_to_fire;
            end

            if (w_new_grant) begin
                r_state       <= c_HOLD;
                r_grant       <= c_ONE << w_sel;
                r_grant_idx   <= IDX_W'(w_sel);
                r_grant_valid <= 1'b1;
            end else if ((r_state == c_IDLE) || w_end) begin
                r_state       <= c_IDLE;
                r_grant       <= '0;
                r_grant_idx   <= c_NO_GRANT;
                r_grant_valid <= 1'b0;
            end
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_grant_arbiter
// Purpose  : Directed self-checking bench for rr_grant_arbiter
//            (NUM_REQ=8, MAX_HOLD=16).
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_grant_arbiter;

    localparam int NUM_REQ  = 8;
    localparam int IDX_W    = 4;
    localparam int MAX_HOLD = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [NUM_REQ-1:0] req;
    logic               owner_release;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               timeout;

    int total = 0;
    int bad   = 0;

    rr_grant_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .IDX_W    (IDX_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .req           (req),
        .owner_release (owner_release),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .grant_valid   (grant_valid),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        enable        = 1'b0;
        req           = '0;
        owner_release = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        enable        = 1'b1;
        req           = 8'hFF;
        owner_release = 1'b0;
        tick();
        tick();
        total++;
        if ({grant, grant_idx, grant_valid, timeout} !== {8'h00, 4'd8, 1'b1 ^ 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got grant=%h idx=%0d v=%b to=%b want grant=00 idx=8 v=0 to=0",
                     grant, grant_idx, grant_valid, timeout);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({grant, grant_idx, grant_valid, timeout} !== {8'h01, 4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_exit_grant: got grant=%h idx=%0d v=%b to=%b want grant=01 idx=0 v=1 to=0",
                     grant, grant_idx, grant_valid, timeout);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] e_grant;
        logic [3:0] e_idx;
        do_reset();
        req    = 8'hFF;
        enable = 1'b1;
        tick();
        owner_release = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            e_idx   = 4'(i % 8);
            e_grant = 8'h01 << (i % 8);
            total++;
            if ({grant, grant_idx, grant_valid} !== {e_grant, e_idx, 1'b1}) begin
                bad++;
                $display("FAIL rotation_step%0d: got grant=%h idx=%0d v=%b want grant=%h idx=%0d v=1",
                         i, grant, grant_idx, grant_valid, e_grant, e_idx);
            end
        end
        owner_release = 1'b0;
    endtask

    task automatic test_skip_wrap();
        logic [3:0] e_idx [3];
        e_idx = '{4'd2, 4'd7, 4'd2};
        do_reset();
        req    = 8'b1000_0100;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({grant_idx, grant_valid} !== {e_idx[i], 1'b1}) begin
                bad++;
                $display("FAIL skip_wrap_step%0d: got idx=%0d v=%b want idx=%0d v=1",
                         i, grant_idx, grant_valid, e_idx[i]);
            end
            owner_release = 1'b1;
        end
        owner_release = 1'b0;
    endtask

    task automatic test_enable_low();
        do_reset();
        req    = 8'h08;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        req    = 8'hFF;
        tick();
        tick();
        tick();
        total++;
        if ({grant, grant_idx, grant_valid} !== {8'h08, 4'd3, 1'b1}) begin
            bad++;
            $display("FAIL enable_low_keep: got grant=%h idx=%0d v=%b want grant=08 idx=3 v=1",
                     grant, grant_idx, grant_valid);
        end
        owner_release = 1'b1;
        tick();
        owner_release = 1'b0;
        total++;
        if ({grant, grant_idx, grant_valid} !== {8'h00, 4'd8, 1'b0}) begin
            bad++;
            $display("FAIL enable_low_release: got grant=%h idx=%0d v=%b want grant=00 idx=8 v=0",
                     grant, grant_idx, grant_valid);
        end
        tick();
        total++;
        if ({grant, grant_idx, grant_valid} !== {8'h00, 4'd8, 1'b0}) begin
            bad++;
            $display("FAIL enable_low_idle: got grant=%h idx=%0d v=%b want grant=00 idx=8 v=0",
                     grant, grant_idx, grant_valid);
        end
        enable = 1'b1;
        tick();
        total++;
        if ({grant, grant_idx, grant_valid} !== {8'h10, 4'd4, 1'b1}) begin
            bad++;
            $display("FAIL enable_resume_ptr: got grant=%h idx=%0d v=%b want grant=10 idx=4 v=1",
                     grant, grant_idx, grant_valid);
        end
    endtask

    task automatic test_drop_release();
        do_reset();
        req    = 8'h10;
        enable = 1'b1;
        tick();
        req           = 8'h40;
        owner_release = 1'b1;
        tick();
        owner_release = 1'b0;
        total++;
        if ({grant_idx, grant_valid} !== {4'd6, 1'b1}) begin
            bad++;
            $display("FAIL drop_plus_release: got idx=%0d v=%b want idx=6 v=1", grant_idx, grant_valid);
        end
        tick();
        total++;
        if ({grant, grant_idx} !== {8'h40, 4'd6}) begin
            bad++;
            $display("FAIL single_end_hold: got grant=%h idx=%0d want grant=40 idx=6", grant, grant_idx);
        end
        req = 8'h02;
        tick();
        total++;
        if ({grant, grant_idx} !== {8'h02, 4'd1}) begin
            bad++;
            $display("FAIL drop_wrap: got grant=%h idx=%0d want grant=02 idx=1", grant, grant_idx);
        end
    endtask

    task automatic test_single_requester();
        do_reset();
        req    = 8'h01;
        enable = 1'b1;
        tick();
        owner_release = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({grant, grant_idx, grant_valid} !== {8'h01, 4'd0, 1'b1}) begin
                bad++;
                $display("FAIL self_regrant%0d: got grant=%h idx=%0d v=%b want grant=01 idx=0 v=1",
                         i, grant, grant_idx, grant_valid);
            end
        end
        owner_release = 1'b0;
        req = 8'h00;
        tick();
        total++;
        if ({grant, grant_idx, grant_valid} !== {8'h00, 4'd8, 1'b0}) begin
            bad++;
            $display("FAIL drop_to_idle: got grant=%h idx=%0d v=%b want grant=00 idx=8 v=0",
                     grant, grant_idx, grant_valid);
        end
    endtask

    task automatic test_hold_timeout();
        do_reset();
        req    = 8'h20;
        enable = 1'b1;
        tick();
        req = 8'h21;
`ifdef ARB_HOLD_TIMEOUT_EN
        begin
            int held_ok = 1;
            for (int i = 1; i <= MAX_HOLD; i++) begin
                if ({grant, timeout} !== {8'h20, 1'b0}) begin
                    held_ok = 0;
                end
                if (i < MAX_HOLD) begin
                    tick();
                end
            end
            total++;
            if (held_ok != 1) begin
                bad++;
                $display("FAIL timeout_hold16: got grant not held 16 cycles, grant=%h to=%b want 20/0",
                         grant, timeout);
            end
            tick();
            total++;
            if ({grant, grant_idx, timeout} !== {8'h01, 4'd0, 1'b1}) begin
                bad++;
                $display("FAIL timeout_fire: got grant=%h idx=%0d to=%b want grant=01 idx=0 to=1",
                         grant, grant_idx, timeout);
            end
            tick();
            total++;
            if ({grant, grant_idx, timeout} !== {8'h01, 4'd0, 1'b0}) begin
                bad++;
                $display("FAIL timeout_pulse_once: got grant=%h idx=%0d to=%b want grant=01 idx=0 to=0",
                         grant, grant_idx, timeout);
            end
        end
`else
        begin
            logic saw_to = 1'b0;
            for (int i = 0; i < 100; i++) begin
                tick();
                saw_to = saw_to | timeout;
            end
            total++;
            if ({grant, grant_idx, saw_to} !== {8'h20, 4'd5, 1'b0}) begin
                bad++;
                $display("FAIL no_timeout_hold: got grant=%h idx=%0d saw_to=%b want grant=20 idx=5 saw_to=0",
                         grant, grant_idx, saw_to);
            end
        end
`endif
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req    = 8'hFF;
        enable = 1'b1;
        tick();
        owner_release = 1'b1;
        tick();
        owner_release = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        total++;
        if ({grant, grant_idx, grant_valid, timeout} !== {8'h00, 4'd8, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_hold: got grant=%h idx=%0d v=%b to=%b want grant=00 idx=8 v=0 to=0",
                     grant, grant_idx, grant_valid, timeout);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({grant, grant_idx} !== {8'h01, 4'd0}) begin
            bad++;
            $display("FAIL reset_clears_ptr: got grant=%h idx=%0d want grant=01 idx=0", grant, grant_idx);
        end
    endtask

    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        req           = '0;
        owner_release = 1'b0;
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_enable_low();
        test_drop_release();
        test_single_requester();
        test_hold_timeout();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Parametrised round-robin arbiter with grant hold, handshake release and an optional hold-timeout. It succeeds the 8-board one-hot arbiter in the board-dispatch path. It serves NUM_REQ requesters (boards or channels) and holds a registered one-hot grant and encoded index until the owner releases it. It then rotates priority to the requester after the last owner.

## Interface
- NUM_REQ, 8: number of requesters, ≥1.
- IDX_W, $clog2(NUM_REQ)+1: encoded index width. Must be wide enough to hold the value NUM_REQ, which is the invalid code.
- MAX_HOLD, 16: maximum cycles a grant may be held before it is forced to end. Used only with ARB_HOLD_TIMEOUT_EN. Must be ≥2.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  permits new grants.
- req  in  NUM_REQ  request vector, level, one bit per requester.
- release  in  1  owner done; single-cycle pulse, ignored when no grant is held.
- grant  out  NUM_REQ  registered one-hot grant; all zero when idle.
- grant_idx  out  IDX_W  index of the granted requester; NUM_REQ when no grant is held.
- grant_valid  out  1  equals |grant.
- timeout  out  1  one-cycle pulse when a grant is forcibly ended.

## Operation
- State: IDLE or HOLD. Registers: ptr, the priority base, 0..NUM_REQ-1; the grant registers; hold_cnt, only when the macro is defined.
- Reset values: state IDLE, ptr 0, grant 0, grant_idx NUM_REQ, grant_valid 0, timeout 0, hold_cnt 0.
- Selection: pick the first set bit of req scanning base, base+1, …, NUM_REQ-1, 0, …, base-1, wrapping modulo NUM_REQ.
- IDLE: if enable and |req, grant the selected requester at base = ptr, then go to HOLD. Otherwise stay in IDLE with outputs idle.
- HOLD ends, for owner k, when any of these occurs:
  - release is high;
  - req[k] is low (owner dropped its request);
  - the timeout fires.
- Simultaneous end conditions count as a single end.
- On end, ptr becomes (k+1) mod NUM_REQ.
- After an end, with enable high:
  - Re-arbitrate in the same cycle with base = (k+1) mod NUM_REQ, excluding nothing else.
  - If a requester is found, the grant switches directly and the state stays HOLD. No idle bubble.
  - If none is found, go to IDLE.
- After an end, with enable low: go to IDLE with no re-arbitration.
- enable low during HOLD does not revoke the current grant; release is still honoured.
- If k is the only requester, it can be re-granted immediately after its own end. This is the NUM_REQ=1 case too; ptr stays 0.
- req changes on bits other than k during HOLD have no effect.
- rst mid-HOLD clears all state on that edge. No timeout pulse is produced.

## Timing
- All outputs are registered.
- req rises at cycle t in IDLE with enable high → grant, grant_idx and grant_valid are valid from t+1.
- End condition at cycle t → at t+1 the grant is either switched to the new owner or cleared. timeout, if it was the cause, is high only in t+1.
- Minimum hold: 1 cycle. An owner releasing in its first granted cycle gives one-cycle grants, round-robin, back to back.
- hold_cnt:
  - cleared whenever a new grant is issued;
  - increments every HOLD cycle;
  - the timeout end condition is hold_cnt == MAX_HOLD-1 with no other end condition in that cycle;
  - so a grant lasts at most MAX_HOLD cycles.
- hold_cnt saturates at MAX_HOLD-1 (no wrap) with width $clog2(MAX_HOLD).
- grant_idx is always consistent with grant in the same cycle.

## Configuration
- ARB_HOLD_TIMEOUT_EN defined:
  - hold_cnt and forced end are compiled in;
  - timeout pulses as described.
- ARB_HOLD_TIMEOUT_EN undefined:
  - no counter;
  - timeout is tied to 0;
  - a grant is held indefinitely until release or owner request drop;
  - MAX_HOLD is unused.

## Test plan
- Reset with req=8'hFF → grant=0, grant_idx=8, grant_valid=0. After rst falls, with enable=1, grant=8'h01 and grant_idx=0 one cycle later.
- req=8'hFF held, release pulsed every cycle → grant_idx sequence 0,1,…,7,0 with no idle cycles; ptr wraps from 7 to 0.
- req=8'b1000_0100, owner 2 holding, release pulsed → next grant_idx=7. Then a release → grant_idx=2 (wrap).
- enable=0 while owner 3 holds → grant is kept. A release then gives grant=0 and grant_idx=8 next cycle, even with other requests pending.
- Macro defined, MAX_HOLD=16, owner 5 never releases → grant is held for exactly 16 cycles. Then timeout pulses for 1 cycle and grant moves to the next requester. Macro undefined → grant is still held after 100 cycles and timeout=0.
- Owner 4 drops req[4] in the same cycle as release, with req[6] set → a single end, next grant_idx=6. Asserting rst mid-HOLD → all outputs reach their reset values on the next edge.
